// File: rtl/kbd_seq_pkg.sv
// Shared types and defaults for the PS/2 keyboard sequencer.
package kbd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } disp_state_t;

  localparam int PS2_FRAME_BITS = 11;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_STROBE_GAP = 4;
  localparam int DEF_CONV_WAIT  = 16;
  localparam int DEF_RX_TIMEOUT = 50000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge sampling, frame check
// and mid-frame timeout. Emits one-cycle valid or err pulses per frame.
module ps2_rx
  import kbd_seq_pkg::*;
#(
  parameter int RX_TIMEOUT = DEF_RX_TIMEOUT
)(
  input  logic       clka,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int TW = $clog2(RX_TIMEOUT + 1);
  localparam int BW = $clog2(PS2_FRAME_BITS + 1);

  logic [1:0]                meta_reg;
  logic [1:0]                sync_reg;
  logic                      clk_prev_reg;
  logic [PS2_FRAME_BITS-1:0] shift_reg;
  logic [BW-1:0]             bit_cnt_reg;
  logic [TW-1:0]             idle_cnt_reg;
  logic [7:0]                byte_reg;
  logic                      valid_reg;
  logic                      err_reg;

  logic                      fall;
  logic                      last_bit;
  logic                      frame_ok;
  logic [PS2_FRAME_BITS-1:0] frame;

  // sync_reg[1] is the clock pin, sync_reg[0] the data pin
  assign fall     = clk_prev_reg & ~sync_reg[1];
  assign frame    = {sync_reg[0], shift_reg[PS2_FRAME_BITS-1:1]};
  assign last_bit = fall && (bit_cnt_reg == BW'(PS2_FRAME_BITS - 1));
  // start low, stop high, data plus parity carry an odd number of ones
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg     <= 2'b11;
      sync_reg     <= 2'b11;
      clk_prev_reg <= 1'b1;
    end else begin
      meta_reg     <= {ps2_clk, ps2_data};
      sync_reg     <= meta_reg;
      clk_prev_reg <= sync_reg[1];
    end
  end

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      idle_cnt_reg <= '0;
      byte_reg     <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      if (fall) begin
        idle_cnt_reg <= '0;
        shift_reg    <= frame;
        if (last_bit) begin
          bit_cnt_reg <= '0;
          if (frame_ok) begin
            byte_reg  <= frame[8:1];
            valid_reg <= 1'b1;
          end else begin
            err_reg <= 1'b1;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end else if (bit_cnt_reg != '0) begin
        // only a partially received frame can time out
        if (idle_cnt_reg == TW'(RX_TIMEOUT - 1)) begin
          bit_cnt_reg  <= '0;
          idle_cnt_reg <= '0;
          err_reg      <= 1'b1;
        end else begin
          idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign rx_byte  = byte_reg;
  assign rx_valid = valid_reg;
  assign rx_err   = err_reg;

endmodule

// File: rtl/kbd_sequencer.sv
// PS/2 keyboard sequencer: receiver, scancode buffer, converter dispatcher and
// ASCII flag register. Define KBD_SEQ_FIFO_EN for a FIFO_DEPTH-entry FIFO.
module kbd_sequencer
  import kbd_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int STROBE_GAP = DEF_STROBE_GAP,
  parameter int CONV_WAIT  = DEF_CONV_WAIT,
  parameter int RX_TIMEOUT = DEF_RX_TIMEOUT
)(
  input  logic       clka,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] conv_scancode,
  output logic       conv_strobe,
  input  logic [7:0] conv_ascii,
  input  logic       conv_key_up,
  input  logic       conv_done,
  output logic [7:0] kbd_char,
  output logic       kbd_flag,
  input  logic       kbd_ack,
  output logic       overrun,
  output logic       frame_err
);

`ifdef KBD_SEQ_FIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int BUF_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
  localparam int OW    = $clog2(BUF_DEPTH + 1);
  localparam int CNT_W = $clog2(max_int(CONV_WAIT, STROBE_GAP) + 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_rx #(
    .RX_TIMEOUT(RX_TIMEOUT)
  ) u_rx (
    .clka     (clka),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  assign frame_err = rx_err;

  logic [OW-1:0] count_reg;
  logic          buf_empty;
  logic          buf_full;
  logic          push;
  logic          pop;
  logic          push_lost;
  logic [7:0]    head;

  assign buf_empty = (count_reg == '0);
  assign buf_full  = (count_reg == OW'(BUF_DEPTH));
  // a pop in the same cycle frees the slot the new byte needs
  assign push      = rx_valid && (!buf_full || pop);
  assign push_lost = rx_valid && buf_full && !pop;

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (push && !pop) begin
      count_reg <= count_reg + 1'b1;
    end else if (pop && !push) begin
      count_reg <= count_reg - 1'b1;
    end
  end

`ifdef KBD_SEQ_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;

  always_ff @(posedge clka) begin
    if (push) mem[wr_ptr_reg] <= rx_byte;
  end

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign head = mem[rd_ptr_reg];
`else
  logic [7:0] hold_reg;

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg <= '0;
    end else if (push) begin
      hold_reg <= rx_byte;
    end
  end

  assign head = hold_reg;
`endif

  disp_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             load_sc;

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    load_sc    = 1'b0;
    case (state_reg)
      IDLE: begin
        // capture the head now so it is stable for the whole ISSUE cycle
        if (!buf_empty) begin
          state_next = ISSUE;
          load_sc    = 1'b1;
        end
      end
      ISSUE: begin
        pop        = 1'b1;
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (conv_done || (cnt_reg == CNT_W'(CONV_WAIT - 1))) begin
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == CNT_W'(STROBE_GAP - 1)) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign conv_strobe = (state_reg == ISSUE);

  logic [7:0] scancode_reg;
  logic [7:0] kbd_char_reg;
  logic       kbd_flag_reg;
  logic       overrun_reg;
  logic       deliver;

  assign deliver = (state_reg == WAIT) && conv_done && !conv_key_up && (conv_ascii != 8'h00);

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      scancode_reg <= '0;
      kbd_char_reg <= '0;
      kbd_flag_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (load_sc) scancode_reg <= head;
      if (deliver) begin
        if (!kbd_flag_reg || kbd_ack) begin
          kbd_char_reg <= conv_ascii;
          kbd_flag_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (kbd_ack) begin
        kbd_flag_reg <= 1'b0;
      end
      if (push_lost) overrun_reg <= 1'b1;
    end
  end

  assign conv_scancode = scancode_reg;
  assign kbd_char      = kbd_char_reg;
  assign kbd_flag      = kbd_flag_reg;
  assign overrun       = overrun_reg;

endmodule

// File: tb/tb_kbd_sequencer.sv
// Self-checking bench for kbd_sequencer: drives PS/2 frames, plays the converter
// and compares against a transaction-level model of buffer and flag register.
module tb_kbd_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int STROBE_GAP = 3;
  localparam int CONV_WAIT  = 1000;
  localparam int RX_TIMEOUT = 300;
  localparam int HALF       = 4;
`ifdef KBD_SEQ_FIFO_EN
  localparam int BUF_CAP = FIFO_DEPTH;
`else
  localparam int BUF_CAP = 1;
`endif

  logic       clka = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] conv_scancode;
  logic       conv_strobe;
  logic [7:0] conv_ascii = 8'h00;
  logic       conv_key_up = 1'b0;
  logic       conv_done = 1'b0;
  logic [7:0] kbd_char;
  logic       kbd_flag;
  logic       kbd_ack = 1'b0;
  logic       overrun;
  logic       frame_err;

  always #5 clka = ~clka;

  kbd_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .STROBE_GAP (STROBE_GAP),
    .CONV_WAIT  (CONV_WAIT),
    .RX_TIMEOUT (RX_TIMEOUT)
  ) dut (
    .clka          (clka),
    .reset_n       (reset_n),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .conv_scancode (conv_scancode),
    .conv_strobe   (conv_strobe),
    .conv_ascii    (conv_ascii),
    .conv_key_up   (conv_key_up),
    .conv_done     (conv_done),
    .kbd_char      (kbd_char),
    .kbd_flag      (kbd_flag),
    .kbd_ack       (kbd_ack),
    .overrun       (overrun),
    .frame_err     (frame_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int ferr_cnt = 0;
  int ferr_cyc = 0;
  int ferr_exp = 0;
  int last_fall_cyc = 0;
  logic [7:0] obs_sc[$];
  int         obs_cyc[$];

  // reference model of the delivery register
  logic [7:0] m_char = 8'h00;
  logic       m_flag = 1'b0;
  logic       m_ovr  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clka);
      cyc++;
      if (conv_strobe === 1'b1) begin
        strobe_cnt++;
        obs_sc.push_back(conv_scancode);
        obs_cyc.push_back(cyc);
      end
      if (frame_err === 1'b1) begin
        ferr_cnt++;
        ferr_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clka);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] sc, input logic bad_par, input logic bad_stop);
    return {~bad_stop, (~^sc) ^ bad_par, sc, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) tick();
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) tick();
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) tick();
  endtask

  task automatic get_strobe(input int prev, input string tag, output logic [7:0] sc, output int c);
    int n = 0;
    while (strobe_cnt == prev && n < 200) begin
      tick();
      n++;
    end
    check_eq({tag, "_strobe_count"}, strobe_cnt, prev + 1);
    sc = 8'h00;
    c  = 0;
    if (obs_sc.size() > 0) begin
      sc = obs_sc.pop_front();
      c  = obs_cyc.pop_front();
    end
  endtask

  task automatic check_kbd(input string tag);
    check_eq({tag, "_kbd_char"}, kbd_char, m_char);
    check_eq({tag, "_kbd_flag"}, kbd_flag, m_flag);
    check_eq({tag, "_overrun"}, overrun, m_ovr);
  endtask

  task automatic deliver(input logic [7:0] ascii, input logic key_up, input logic ack, input string tag);
    conv_done   = 1'b1;
    conv_ascii  = ascii;
    conv_key_up = key_up;
    kbd_ack     = ack;
    tick();
    conv_done   = 1'b0;
    conv_ascii  = 8'h00;
    conv_key_up = 1'b0;
    kbd_ack     = 1'b0;
    if (!key_up && ascii != 8'h00) begin
      if (!m_flag || ack) begin
        m_char = ascii;
        m_flag = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (ack) begin
      m_flag = 1'b0;
    end
    check_kbd(tag);
  endtask

  task automatic ack_only(input string tag);
    kbd_ack = 1'b1;
    tick();
    kbd_ack = 1'b0;
    m_flag  = 1'b0;
    check_kbd(tag);
  endtask

  task automatic txn(input logic [7:0] sc, input logic [7:0] ascii, input logic key_up,
                     input logic ack, input string tag);
    int prev = strobe_cnt;
    logic [7:0] got;
    int c;
    send_bits(mk_frame(sc, 1'b0, 1'b0), 11);
    get_strobe(prev, tag, got, c);
    check_eq({tag, "_scancode"}, got, sc);
    repeat ($urandom_range(0, 5)) tick();
    deliver(ascii, key_up, ack, tag);
    $display("txn %s: sc=%02h ascii=%02h key_up=%0b ack=%0b -> char=%02h flag=%0b overrun=%0b",
             tag, sc, ascii, key_up, ack, kbd_char, kbd_flag, overrun);
    repeat (STROBE_GAP + 3) tick();
  endtask

  task automatic bad_frame(input logic [10:0] f, input string tag);
    int ps = strobe_cnt;
    int pe = ferr_cnt;
    send_bits(f, 11);
    repeat (30) tick();
    ferr_exp++;
    check_eq({tag, "_frame_err_pulses"}, ferr_cnt, pe + 1);
    check_eq({tag, "_no_strobe"}, strobe_cnt, ps);
    $display("txn %s: frame=%03h frame_err pulses=%0d strobes=%0d", tag, f, ferr_cnt - pe, strobe_cnt - ps);
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] sc, ascii, got;
    logic [7:0] q[$];
    int prev, pe, n, c, t_prev;
    logic ok;

    repeat (3) tick();
    check_eq("rst_conv_scancode", conv_scancode, 8'h00);
    check_eq("rst_conv_strobe", conv_strobe, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_kbd("rst");
    reset_n = 1'b1;
    repeat (5) tick();

    txn(8'h1C, 8'h61, 1'b0, 1'b0, "t1c");
    ack_only("ack_clear");
    txn(8'h21, 8'h41, 1'b0, 1'b0, "first_char");
    txn(8'h22, 8'h42, 1'b0, 1'b1, "ack_same_cycle");

    bad_frame(mk_frame(8'h55, 1'b1, 1'b0), "bad_parity");
    bad_frame(mk_frame(8'h36, 1'b0, 1'b1), "bad_stop");
    sc = 8'h48;
    bad_frame(mk_frame(sc, 1'b0, 1'b0) | 11'h001, "bad_start");

    // abandoned frame: five bits then silence
    pe = ferr_cnt;
    send_bits(mk_frame(8'h77, 1'b0, 1'b0), 5);
    n = 0;
    while (ferr_cnt == pe && n < RX_TIMEOUT + 100) begin
      tick();
      n++;
    end
    ferr_exp++;
    check_eq("timeout_frame_err", ferr_cnt, pe + 1);
    ok = (ferr_cyc - last_fall_cyc >= RX_TIMEOUT - 2) && (ferr_cyc - last_fall_cyc <= RX_TIMEOUT + 8);
    check_eq("timeout_latency", ok, 1'b1);
    $display("txn timeout: frame_err %0d cycles after last ps2_clk fall", ferr_cyc - last_fall_cyc);
    txn(8'h2A, 8'h2B, 1'b0, 1'b1, "after_timeout");

    for (int i = 0; i < 16; i++) begin
      sc    = 8'($urandom_range(0, 255));
      ascii = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) ack_only("rand_ack");
      txn(sc, ascii, ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), "rand");
    end

    txn(8'h31, 8'h51, 1'b0, 1'b1, "load_before_ovr");
    txn(8'h32, 8'h52, 1'b0, 1'b0, "char_lost");

    // reset while the dispatcher waits on the converter
    txn(8'h33, 8'h53, 1'b0, 1'b1, "pre_reset");
    prev = strobe_cnt;
    send_bits(mk_frame(8'h44, 1'b0, 1'b0), 11);
    get_strobe(prev, "reset_wait", got, c);
    repeat (3) tick();
    reset_n = 1'b0;
    #2;
    m_char = 8'h00;
    m_flag = 1'b0;
    m_ovr  = 1'b0;
    check_eq("reset_conv_scancode", conv_scancode, 8'h00);
    check_eq("reset_conv_strobe", conv_strobe, 1'b0);
    check_eq("reset_frame_err", frame_err, 1'b0);
    check_kbd("reset");
    $display("txn reset: char=%02h flag=%0b overrun=%0b scancode=%02h", kbd_char, kbd_flag, overrun, conv_scancode);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    txn(8'h5A, 8'h7A, 1'b0, 1'b0, "after_reset");

    // burst while the converter stays silent: buffer fills, extras are dropped
    prev = strobe_cnt;
    send_bits(mk_frame(8'h10, 1'b0, 1'b0), 11);
    get_strobe(prev, "burst_first", got, t_prev);
    check_eq("burst_first_scancode", got, 8'h10);
    for (int k = 0; k < BUF_CAP + 2; k++) begin
      sc = 8'($urandom_range(0, 255));
      send_bits(mk_frame(sc, 1'b0, 1'b0), 11);
      if (q.size() < BUF_CAP) q.push_back(sc);
      else m_ovr = 1'b1;
    end
    check_eq("burst_overrun", overrun, m_ovr);
    check_eq("burst_no_early_strobe", strobe_cnt, prev + 1);
    while (q.size() > 0) begin
      sc = q.pop_front();
      n = 0;
      while (obs_sc.size() == 0 && n < CONV_WAIT + STROBE_GAP + 50) begin
        tick();
        n++;
      end
      check_eq("burst_strobe_seen", (obs_sc.size() > 0), 1'b1);
      if (obs_sc.size() > 0) begin
        got = obs_sc.pop_front();
        c   = obs_cyc.pop_front();
        check_eq("burst_scancode", got, sc);
        check_eq("burst_spacing", c - t_prev, CONV_WAIT + STROBE_GAP + 2);
        $display("txn burst: sc=%02h spacing=%0d", got, c - t_prev);
        t_prev = c;
      end
    end
    repeat (CONV_WAIT + STROBE_GAP + 20) tick();
    check_eq("burst_total_strobes", strobe_cnt, prev + 1 + BUF_CAP);
    check_eq("burst_overrun_sticky", overrun, m_ovr);
    check_eq("frame_err_total", ferr_cnt, ferr_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
